// File: rtl/sub_unit.sv
// Registered ripple-borrow subtractor: y = a - b - cin with borrow-out,
// zero and signed-overflow flags, plus a valid strobe for en=1 captures.
module sub_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             valid
);

  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   borrow;

  logic [WIDTH-1:0] y_d, y_q;
  logic             cout_d, cout_q;
  logic             zero_d, zero_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;

  assign borrow[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  always_comb begin
    y_d     = y_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (en) begin
      y_d     = diff;
      cout_d  = borrow[WIDTH];
      zero_d  = (diff == '0);
      ovf_d   = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign cout  = cout_q;
  assign zero  = zero_q;
  assign ovf   = ovf_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_sub_unit.sv
// Bench for sub_unit: directed vector table at WIDTH=4, reset/hold sequences,
// and random checks against a WIDTH+1-bit subtraction model at WIDTH=4 and 8.
module tb_sub_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en4, cin4, cout4, zero4, ovf4, valid4;
  logic [3:0] a4, b4, y4;
  logic       en8, cin8, cout8, zero8, ovf8, valid8;
  logic [7:0] a8, b8, y8;

  sub_unit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .a(a4), .b(b4), .cin(cin4),
    .y(y4), .cout(cout4), .zero(zero4), .ovf(ovf4), .valid(valid4)
  );

  sub_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8), .cin(cin8),
    .y(y8), .cout(cout8), .zero(zero8), .ovf(ovf8), .valid(valid8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] y;
    logic       cout;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t vecs [13];
  int total = 0;
  int bad   = 0;

  task automatic chk4(input string name, input logic [3:0] ey, input logic ec,
                      input logic ez, input logic eo, input logic ev);
    total++;
    if ({y4, cout4, zero4, ovf4, valid4} !== {ey, ec, ez, eo, ev}) begin
      bad++;
      $display("FAIL %s: got y=%h cout=%b zero=%b ovf=%b valid=%b, want y=%h cout=%b zero=%b ovf=%b valid=%b",
               name, y4, cout4, zero4, ovf4, valid4, ey, ec, ez, eo, ev);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] ey, input logic ec,
                      input logic ez, input logic eo, input logic ev);
    total++;
    if ({y8, cout8, zero8, ovf8, valid8} !== {ey, ec, ez, eo, ev}) begin
      bad++;
      $display("FAIL %s: got y=%h cout=%b zero=%b ovf=%b valid=%b, want y=%h cout=%b zero=%b ovf=%b valid=%b",
               name, y8, cout8, zero8, ovf8, valid8, ey, ec, ez, eo, ev);
    end
  endtask

  initial begin
    logic [4:0] r5;
    logic [8:0] r9;

    vecs[0]  = '{4'd1,  4'd0,  1'b0, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'd3,  4'd1,  1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'd5,  4'd2,  1'b0, 4'h3, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd11, 4'd7,  1'b0, 4'h4, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{4'd8,  4'd3,  1'b1, 4'h4, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{4'd15, 4'd8,  1'b1, 4'h6, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd0,  4'd1,  1'b0, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'd5,  4'd5,  1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{4'd8,  4'd1,  1'b0, 4'h7, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'd7,  4'd15, 1'b0, 4'h8, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{4'd15, 4'd0,  1'b0, 4'hF, 1'b0, 1'b0, 1'b0};

    en4 = 1'b1; a4 = 4'hF; b4 = 4'h0; cin4 = 1'b0;
    en8 = 1'b0; a8 = '0;   b8 = '0;   cin8 = 1'b0;

    // Reset held across an edge with en=1: nothing is captured.
    @(posedge clk); #1;
    chk4("reset_hold", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk8("reset_hold8", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk4("first_after_reset", 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset away from any clock edge.
    @(negedge clk); rst = 1'b1; a4 = 4'h3; b4 = 4'h1;
    #1;
    chk4("async_reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      en4 = 1'b1; a4 = vecs[i].a; b4 = vecs[i].b; cin4 = vecs[i].cin;
      @(posedge clk); #1;
      chk4($sformatf("vec%0d", i), vecs[i].y, vecs[i].cout, vecs[i].zero, vecs[i].ovf, 1'b1);
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en4 = 1'b0; a4 = 4'(i + 2); b4 = 4'(7 - i); cin4 = i[0];
      @(posedge clk); #1;
      chk4($sformatf("hold%0d", i), 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      en4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      r5 = {1'b0, a4} - {1'b0, b4} - {4'b0, cin4};
      @(posedge clk); #1;
      chk4("rand4", r5[3:0], r5[4], r5[3:0] == 4'h0,
           (a4[3] ^ b4[3]) & (r5[3] ^ a4[3]), 1'b1);
    end

    @(negedge clk); en4 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      en8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (i % 50 == 0) b8 = a8;
      r9 = {1'b0, a8} - {1'b0, b8} - {8'b0, cin8};
      @(posedge clk); #1;
      chk8("rand8", r9[7:0], r9[8], r9[7:0] == 8'h00,
           (a8[7] ^ b8[7]) & (r9[7] ^ a8[7]), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
